// File: rtl/riscv_dmem_arbiter.sv
// Purpose: shares the single-port data memory between the core (port 0) and a debug/loader port (port 1).
// Latency: grant is combinational in cycle N; rvalid/rdata return in cycle N+1, one access per cycle.
// Backpressure: port 0 has fixed priority and stalls the core when not granted; port 1 is forced through after MAX_WAIT lost conflicts.
module riscv_dmem_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_p0_req,
   input  logic              i_p0_we,
   input  logic [ADDR_W-1:0] i_p0_addr,
   input  logic [DATA_W-1:0] i_p0_wdata,
   input  logic [3:0]        i_p0_wstrb,
   input  logic              i_p1_req,
   input  logic              i_p1_we,
   input  logic [ADDR_W-1:0] i_p1_addr,
   input  logic [DATA_W-1:0] i_p1_wdata,
   input  logic [3:0]        i_p1_wstrb,
   output logic              o_p0_gnt,
   output logic              o_p1_gnt,
   output logic              o_p0_rvalid,
   output logic              o_p1_rvalid,
   output logic [DATA_W-1:0] o_p0_rdata,
   output logic [DATA_W-1:0] o_p1_rdata,
   output logic              o_core_stall,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [3:0]        o_mem_wstrb,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

   logic [3:0] r_starve_cnt;
   logic       r_rsp_valid;
   logic       r_rsp_owner;
   logic       r_rsp_we;
   logic       w_force_p1;
   logic       w_p0_gnt;
   logic       w_p1_gnt;
   logic       w_p0_hit;
   logic       w_p1_hit;

   // Grant: port 0 wins conflicts unless port 1 has lost MAX_WAIT times in a row; nothing is granted in reset
   always_comb begin
      w_force_p1 = (r_starve_cnt == LP_MAX_WAIT);
      w_p1_gnt   = !i_reset && i_p1_req && (!i_p0_req || w_force_p1);
      w_p0_gnt   = !i_reset && i_p0_req && !w_p1_gnt;
   end

   // Memory command mux: forward the granted port, drive zeros when idle
   always_comb begin
      o_mem_en    = w_p0_gnt | w_p1_gnt;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_wstrb = '0;
      if (w_p0_gnt) begin
         o_mem_we    = i_p0_we;
         o_mem_addr  = i_p0_addr;
         o_mem_wdata = i_p0_wdata;
         o_mem_wstrb = i_p0_wstrb;
      end else if (w_p1_gnt) begin
         o_mem_we    = i_p1_we;
         o_mem_addr  = i_p1_addr;
         o_mem_wdata = i_p1_wdata;
         o_mem_wstrb = i_p1_wstrb;
      end
   end

   // Starvation counter: counts consecutive port 1 losses, saturating at MAX_WAIT
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_starve_cnt <= '0;
      end else if (w_p1_gnt || !i_p1_req) begin
         r_starve_cnt <= '0;
      end else if (w_p0_gnt && (r_starve_cnt < LP_MAX_WAIT)) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   // Response tracking: remember who owns the access issued this cycle and whether it was a write
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_owner <= 1'b0;
         r_rsp_we    <= 1'b0;
      end else begin
         r_rsp_valid <= o_mem_en;
         r_rsp_owner <= w_p1_gnt;
         r_rsp_we    <= o_mem_we;
      end
   end

   // Response steering: rvalid to the owner (reset drops any pending response), rdata only for reads
   always_comb begin
      w_p0_hit     = r_rsp_valid && !r_rsp_owner && !i_reset;
      w_p1_hit     = r_rsp_valid &&  r_rsp_owner && !i_reset;
      o_p0_gnt     = w_p0_gnt;
      o_p1_gnt     = w_p1_gnt;
      o_p0_rvalid  = w_p0_hit;
      o_p1_rvalid  = w_p1_hit;
      o_p0_rdata   = (w_p0_hit && !r_rsp_we) ? i_mem_rdata : '0;
      o_p1_rdata   = (w_p1_hit && !r_rsp_we) ? i_mem_rdata : '0;
      o_core_stall = i_p0_req && !w_p0_gnt;
   end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Purpose: directed bench for riscv_dmem_arbiter with a one-cycle-latency byte-strobed memory behind it.
// Latency: inputs change on the falling edge; outputs are sampled 1 ns later.
// Backpressure: requests are held by the sequence itself until the expected grant.
module tb_riscv_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [5:0]  p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;
   logic [3:0]  p0_wstrb, p1_wstrb;
   logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, core_stall;
   logic [31:0] p0_rdata, p1_rdata;
   logic        mem_en, mem_we;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   logic [31:0] mem [64];
   int          n_vec;
   int          n_err;
   logic [4:0]  pat;

   riscv_dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_WAIT(4)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_wstrb(p0_wstrb),
      .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_wstrb(p1_wstrb),
      .o_p0_gnt(p0_gnt), .o_p1_gnt(p1_gnt), .o_p0_rvalid(p0_rvalid), .o_p1_rvalid(p1_rvalid),
      .o_p0_rdata(p0_rdata), .o_p1_rdata(p1_rdata), .o_core_stall(core_stall),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory: byte-strobed writes, registered read data one cycle after the strobe
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= mem[mem_addr];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic req, input logic we, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; p0_wstrb = s;
   endtask

   task automatic drv1(input logic req, input logic we, input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_wstrb = s;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      mem_rdata = '0;
      reset = 1'b1;
      drv0(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      drv1(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      repeat (2) @(negedge clk);

      // Requests during reset are not granted
      drv0(1'b1, 1'b0, 6'd1, 32'h0, 4'h0);
      drv1(1'b1, 1'b0, 6'd1, 32'h0, 4'h0);
      #1;
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_p1_gnt", p1_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_p0_rvalid", p0_rvalid, 0);
      chk("rst_p1_rvalid", p1_rvalid, 0);
      chk("rst_p0_rdata", p0_rdata, 0);

      // Idle after reset
      @(negedge clk);
      reset = 1'b0;
      drv0(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      drv1(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      #1;
      chk("idle_mem_en", mem_en, 0);
      chk("idle_gnt", {p0_gnt, p1_gnt}, 0);
      chk("idle_p0_rvalid", p0_rvalid, 0);
      chk("idle_mem_addr", mem_addr, 0);

      // Preload addr 3 through port 1
      @(negedge clk);
      drv1(1'b1, 1'b1, 6'd3, 32'hDEADBEEF, 4'hF);
      #1;
      chk("pre3_p1_gnt", p1_gnt, 1);
      chk("pre3_p0_gnt", p0_gnt, 0);
      chk("pre3_mem_en", mem_en, 1);
      chk("pre3_mem_we", mem_we, 1);
      chk("pre3_mem_addr", mem_addr, 3);
      chk("pre3_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("pre3_mem_wstrb", mem_wstrb, 4'hF);
      chk("pre3_stall", core_stall, 0);

      // Preload addr 2; write ack for the previous access
      @(negedge clk);
      drv1(1'b1, 1'b1, 6'd2, 32'h11223344, 4'hF);
      #1;
      chk("pre2_p1_gnt", p1_gnt, 1);
      chk("ack3_p1_rvalid", p1_rvalid, 1);
      chk("ack3_p1_rdata", p1_rdata, 0);
      chk("ack3_p0_rvalid", p0_rvalid, 0);

      // Single port 0 read of addr 3
      @(negedge clk);
      drv1(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      drv0(1'b1, 1'b0, 6'd3, 32'h0, 4'h0);
      #1;
      chk("rd3_p0_gnt", p0_gnt, 1);
      chk("rd3_mem_we", mem_we, 0);
      chk("rd3_mem_addr", mem_addr, 3);
      chk("ack2_p1_rvalid", p1_rvalid, 1);

      @(negedge clk);
      drv0(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      #1;
      chk("rd3_p0_rvalid", p0_rvalid, 1);
      chk("rd3_p0_rdata", p0_rdata, 32'hDEADBEEF);
      chk("rd3_p1_rvalid", p1_rvalid, 0);
      chk("rd3_p1_rdata", p1_rdata, 0);

      // Port 1 writes 0x14 to addr 5, port 0 reads it the next cycle
      @(negedge clk);
      drv1(1'b1, 1'b1, 6'd5, 32'h00000014, 4'hF);
      #1;
      chk("wr5_p1_gnt", p1_gnt, 1);

      @(negedge clk);
      drv1(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      drv0(1'b1, 1'b0, 6'd5, 32'h0, 4'h0);
      #1;
      chk("rd5_p0_gnt", p0_gnt, 1);
      chk("wr5_p1_rvalid", p1_rvalid, 1);
      chk("wr5_p1_rdata", p1_rdata, 0);

      // Byte-strobed write to addr 2 while the addr 5 read returns
      @(negedge clk);
      drv0(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      drv1(1'b1, 1'b1, 6'd2, 32'hAABBCCDD, 4'b0101);
      #1;
      chk("rd5_p0_rvalid", p0_rvalid, 1);
      chk("rd5_p0_rdata", p0_rdata, 32'h00000014);
      chk("wstrb_p1_gnt", p1_gnt, 1);
      chk("wstrb_mem_wstrb", mem_wstrb, 4'b0101);

      @(negedge clk);
      drv1(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      drv0(1'b1, 1'b0, 6'd2, 32'h0, 4'h0);
      #1;
      chk("rd2_p0_gnt", p0_gnt, 1);

      @(negedge clk);
      drv0(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      #1;
      chk("rd2_p0_rdata", p0_rdata, 32'h11BB33DD);

      // Starvation: both request continuously, expect p0 x4 then p1, twice
      pat = 5'b10000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drv0(1'b1, 1'b0, 6'd3, 32'h0, 4'h0);
         drv1(1'b1, 1'b0, 6'd2, 32'h0, 4'h0);
         #1;
         chk($sformatf("starve%0d_p1_gnt", i), p1_gnt, pat[i % 5]);
         chk($sformatf("starve%0d_p0_gnt", i), p0_gnt, !pat[i % 5]);
         chk($sformatf("starve%0d_stall", i), core_stall, pat[i % 5]);
         if (i == 1) chk("starve_p0_rdata", p0_rdata, 32'hDEADBEEF);
         if (i == 5) begin
            chk("starve_p1_rvalid", p1_rvalid, 1);
            chk("starve_p1_rdata", p1_rdata, 32'h11BB33DD);
            chk("starve_p0_rvalid", p0_rvalid, 0);
         end
      end

      // Withdrawn request: p1 loses twice, then drops
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("wd%0d_p1_gnt", i), p1_gnt, 0);
         chk($sformatf("wd%0d_p0_gnt", i), p0_gnt, 1);
      end
      @(negedge clk);
      drv1(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      #1;
      chk("wd_drop_p1_gnt", p1_gnt, 0);
      chk("wd_drop_p1_rvalid", p1_rvalid, 0);

      // Counter must be back at 0: four p0 wins before p1 is forced through
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drv1(1'b1, 1'b0, 6'd2, 32'h0, 4'h0);
         #1;
         chk($sformatf("wdclr%0d_p1_gnt", i), p1_gnt, pat[i]);
         if (i < 5) chk($sformatf("wdclr%0d_p1_rvalid", i), p1_rvalid, 0);
      end

      // Reset mid-operation: build up three losses, then reset right after a p0 grant
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("prerst%0d_p0_gnt", i), p0_gnt, 1);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_p0_rvalid", p0_rvalid, 0);
      chk("midrst_gnt", {p0_gnt, p1_gnt}, 0);
      chk("midrst_mem_en", mem_en, 0);

      @(negedge clk);
      #1;
      chk("midrst2_p0_rvalid", p0_rvalid, 0);
      chk("midrst2_gnt", {p0_gnt, p1_gnt}, 0);

      // After release the counter restarts from 0
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         reset = 1'b0;
         #1;
         chk($sformatf("postrst%0d_p0_gnt", i), p0_gnt, !pat[i]);
         chk($sformatf("postrst%0d_p1_gnt", i), p1_gnt, pat[i]);
         if (i == 0) chk("postrst_p0_rvalid", p0_rvalid, 0);
      end

      @(negedge clk);
      drv0(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      drv1(1'b0, 1'b0, 6'd0, 32'h0, 4'h0);
      #1;
      chk("end_p1_rvalid", p1_rvalid, 1);
      chk("end_mem_en", mem_en, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
